// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs the imem request/ready handshake.
// Holds one fetched word for decode and steps the PC when that word retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_accept,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Jalr,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        req;
    logic [31:0] target;
    logic        capture;
    logic        take;
    logic        trap;

    assign imem_req  = req;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // Next-PC selection; Jalr outranks Branch/Jump, bit 0 of the jalr target is dropped
    always_comb begin
        target = pc_plus4;
        if (Jalr) begin
            target = {alu_result[31:1], 1'b0};
        end else if (Branch || Jump) begin
            target = pc + imm_ext;
        end
    end

    // Next-state and transition strobes for the fetch FSM
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        take       = 1'b0;
        trap       = 1'b0;
        case (state)
            REQ: begin
                if (req && imem_ready) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                if (instr_accept && instr_valid) begin
                    if (target[1:0] == 2'b00) begin
                        state_next = REQ;
                        take       = 1'b1;
                    end else begin
                        state_next = HALT;
                        trap       = 1'b1;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // State, PC and held-instruction registers; request is registered off the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= REQ;
            req          <= 1'b0;
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            req   <= (state_next == REQ);
            if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (take) begin
                pc          <= target;
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
            if (trap) begin
                misalign_err <= 1'b1;
                instr        <= NOP_INSTR;
                instr_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, next-PC selection,
// misalignment halt, wrap-around and reset in the middle of a request.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_accept;
    logic        Branch;
    logic        Jump;
    logic        Jalr;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        misalign_err;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_accept(instr_accept),
        .Branch      (Branch),
        .Jump        (Jump),
        .Jalr        (Jalr),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve one fetch after 'waits' idle cycles; request must stay stable meanwhile
    task automatic fetch(input logic [31:0] word, input int waits, input logic [31:0] addr);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            tick();
        end
        chk("req_before", {31'd0, imem_req}, 32'd1);
        chk("addr_before", imem_addr, addr);
        chk("valid_before", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hX;
        chk("valid_after", {31'd0, instr_valid}, 32'd1);
        chk("instr_after", instr, word);
        chk("req_hold", {31'd0, imem_req}, 32'd0);
        chk("pc_hold", pc, addr);
    endtask

    task automatic accept(input logic br, input logic jp, input logic jr,
                          input logic [31:0] imm, input logic [31:0] alu);
        instr_accept = 1'b1;
        Branch       = br;
        Jump         = jp;
        Jalr         = jr;
        imm_ext      = imm;
        alu_result   = alu;
        tick();
        instr_accept = 1'b0;
        Branch       = 1'b0;
        Jump         = 1'b0;
        Jalr         = 1'b0;
        imm_ext      = 32'h0;
        alu_result   = 32'h0;
    endtask

    initial begin
        reset        = 1'b1;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        instr_accept = 1'b0;
        Branch       = 1'b0;
        Jump         = 1'b0;
        Jalr         = 1'b0;
        imm_ext      = 32'h0;
        alu_result   = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("req_up", {31'd0, imem_req}, 32'd1);
        chk("pc4_0", pc_plus4, 32'h4);

        // sequential step with one wait cycle
        fetch(32'h0050_0093, 1, 32'h0);
        accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("seq_req", {31'd0, imem_req}, 32'd1);
        chk("seq_addr", imem_addr, 32'h4);
        chk("seq_nop", instr, NOP);
        chk("seq_valid", {31'd0, instr_valid}, 32'd0);

        // jal to 0x40, then taken backward branch
        fetch(32'h0000_006F, 0, 32'h4);
        accept(1'b0, 1'b1, 1'b0, 32'h3C, 32'h0);
        chk("jal_addr", imem_addr, 32'h40);
        fetch(32'hFE00_0CE3, 0, 32'h40);
        accept(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        chk("br_taken", imem_addr, 32'h38);

        // back to 0x40, branch not taken
        fetch(32'h0080_006F, 0, 32'h38);
        accept(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        chk("jal_back", imem_addr, 32'h40);
        fetch(32'hFE00_0CE3, 0, 32'h40);
        accept(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        chk("br_not", imem_addr, 32'h44);

        // jalr to 0x10, then Jalr beats Jump and drops bit 0
        fetch(32'h0000_8067, 0, 32'h44);
        accept(1'b0, 1'b0, 1'b1, 32'h0, 32'h10);
        chk("jalr_10", pc, 32'h10);
        fetch(32'h0000_8067, 0, 32'h10);
        accept(1'b0, 1'b1, 1'b1, 32'h100, 32'h201);
        chk("jalr_prio", pc, 32'h200);
        chk("jalr_err", {31'd0, misalign_err}, 32'd0);

        // accept while nothing is held is ignored
        instr_accept = 1'b1;
        Jump         = 1'b1;
        imm_ext      = 32'h8;
        tick();
        instr_accept = 1'b0;
        Jump         = 1'b0;
        imm_ext      = 32'h0;
        chk("idle_acc", imem_addr, 32'h200);

        // three wait states, then jalr to the top of the address space
        fetch(32'h0000_0013, 3, 32'h200);
        accept(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 0, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_pc", pc, 32'h0);

        // reach 0x80, then reset while memory answers
        fetch(32'h0000_006F, 0, 32'h0);
        accept(1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
        chk("at_80", imem_addr, 32'h80);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        imem_ready = 1'b0;
        chk("mid_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_pc", pc, 32'h0);
        chk("mid_instr", instr, NOP);
        tick();
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        chk("mid_addr", imem_addr, 32'h0);

        // misaligned jump halts the stage
        fetch(32'h0060_006F, 0, 32'h0);
        accept(1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_pc", pc, 32'h0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        chk("mis_instr", instr, NOP);
        instr_accept = 1'b1;
        imem_ready   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("halt_req", {31'd0, imem_req}, 32'd0);
        end
        instr_accept = 1'b0;
        imem_ready   = 1'b0;
        chk("halt_pc", pc, 32'h0);
        chk("halt_err", {31'd0, misalign_err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("clr_err", {31'd0, misalign_err}, 32'd0);
        tick();
        fetch(32'h0050_0093, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the main decoder and control path in the multi-cycle-memory RISC-V core.
- Owns the PC register and drives a request/ready handshake to instruction memory.
- Presents a held instruction word plus PC to decode/execute.
- Computes the next PC from the Branch/Jump/Jalr controls returned by the decoder when the instruction retires (instr_accept).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; equals pc
imem_ready  in  1  memory response strobe; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  held instruction to decoder
instr_valid  out  1  instr/pc hold a fetched, unretired instruction
pc  out  32  address of instr
pc_plus4  out  32  pc + 4, combinational, mod 2^32
instr_accept  in  1  execute retires the held instruction this cycle
Branch  in  1  taken-branch from decoder
Jump  in  1  jal from decoder
Jalr  in  1  jalr from decoder
imm_ext  in  32  sign-extended immediate (branch/jal offset)
alu_result  in  32  jalr target (rs1 + imm)
misalign_err  out  1  sticky: a computed next PC was not 4-byte aligned

Behaviour:
- One clock (clk). Reset is synchronous and active-high; it takes effect on the rising edge where reset=1 and overrides all other inputs, from any state, including mid-request.
- Reset values:
  - pc=RESET_PC; state=REQ.
  - instr=NOP_INSTR, instr_valid=0, misalign_err=0.
  - imem_req=0 during the reset cycle (registered), then 1 from the first cycle in REQ.
- FSM states: REQ, HOLD, HALT.
- REQ:
  - imem_req=1, imem_addr=pc, held stable until imem_ready.
  - On a cycle with imem_ready=1: instr<=imem_rdata, instr_valid<=1, state<=HOLD.
  - imem_ready is ignored when imem_req=0.
- HOLD:
  - imem_req=0; instr, pc and instr_valid are held.
  - instr_accept=1 selects the next PC, in priority order:
    - Jalr: next = {alu_result[31:1],1'b0}
    - else Branch|Jump: next = pc + imm_ext
    - else: next = pc + 4
  - All additions are 32-bit, carry discarded, and wrap modulo 2^32.
  - If next[1:0]==2'b00: pc<=next, instr_valid<=0, instr<=NOP_INSTR, state<=REQ.
  - Otherwise: misalign_err<=1, instr_valid<=0, instr<=NOP_INSTR, pc unchanged, state<=HALT.
- HALT: imem_req=0; all outputs held; only reset exits.
- instr_accept while instr_valid=0 is ignored. Branch/Jump/Jalr/imm_ext/alu_result are sampled only on an accepted cycle.
- Latency:
  - Request to instr_valid rising = memory latency (imem_ready cycle) + 1.
  - Accept to next imem_req = 1 cycle.
  - Zero-wait memory (imem_ready on the first request cycle) therefore gives a 2-cycle fetch-to-valid.
- At most one outstanding request. No prefetch and no request during HOLD.

Test Plan:
- Reset then sequential: RESET_PC=0, imem_ready 1 cycle after req with rdata=0x00500093 → imem_addr=0, instr=0x00500093, instr_valid=1, pc=0; accept with no controls → next imem_addr=0x4.
- Taken branch: pc=0x40, Branch=1, imm_ext=0xFFFFFFF8, accept → next imem_addr=0x38; same case with Branch=0 → 0x44.
- Jalr priority: pc=0x10, Jump=1, Jalr=1, alu_result=0x201, imm_ext=0x100, accept → pc=0x200 (LSB cleared, Jalr wins), misalign_err=0.
- Misalignment: Jump=1, pc=0x0, imm_ext=0x6, accept → misalign_err=1, state HALT, imem_req stays 0 for 10+ cycles, pc=0x0; then reset → misalign_err=0, fetch at RESET_PC.
- Wait states and wrap: imem_ready delayed 3 cycles → imem_req/imem_addr stable throughout, instr_valid rises the cycle after imem_ready. With pc=0xFFFFFFFC and a sequential accept → pc=0x00000000, pc_plus4 before the accept = 0x0.
- Reset mid-request: reset asserted in REQ at imem_addr=0x80 while imem_ready=1 → instr_valid=0, pc=RESET_PC the next cycle, rdata discarded.
